// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge FSM state type.
// Imported by the register bridge and its testbench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  // Only aligned 32-bit accesses reach the peripheral.
  function automatic logic xfer_legal(
    input logic [2:0] size,
    input logic [1:0] addr_lo
  );
    return (size == HSIZE_WORD) && (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave to simple register-peripheral bridge.
// Ports: AHB slave (HSEL..HRESP), peripheral side (rd_en, wr_en,
// address, wr_data, rd_data, ready, error); clk, rst (async, low).
module ahb_reg_bridge
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ready,
  input  logic                  error
);

  state_e state_q, state_d;

  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] word_addr;

  // SEQ vs NONSEQ is irrelevant: every access is single-beat.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign accept    = HSEL && HREADY && HTRANS[1];
  assign legal     = xfer_legal(HSIZE, HADDR[1:0]);
  assign word_addr = {2'b00, HADDR[ADDR_WIDTH-1:2]};

  assign address = addr_q;
  assign HRDATA  = rdata_q;
  assign wr_data = HWDATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;

    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        // Address phases are only sampled while
        // HREADYOUT is high, i.e. in these two states.
        if (state_q == ST_ERR2) begin
          HRESP = HRESP_ERROR;
        end
        state_d = ST_IDLE;
        if (accept) begin
          if (legal) begin
            state_d = ST_ACCESS;
            write_d = HWRITE;
            addr_d  = word_addr;
          end else begin
            state_d = ST_ERR1;
          end
        end
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        rd_en     = !write_q;
        wr_en     = write_q;
        if (ready) begin
          state_d = ST_CHECK;
          if (!write_q) begin
            rdata_d = rd_data;
          end
        end
      end
      ST_CHECK: begin
        // error is only valid the cycle after the strobe.
        HREADYOUT = 1'b0;
        state_d   = error ? ST_ERR1 : ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Directed testbench for ahb_reg_bridge with a 16-word
// register-file model on the peripheral side.
module tb_ahb_reg_bridge;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        pready;
  logic        perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign HREADY = HREADYOUT;

  ahb_reg_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .address  (address),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ready    (pready),
    .error    (perr)
  );

  // Peripheral model: 16 words, error one cycle after an
  // out-of-range access completes.
  logic [31:0] mem [16];
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];
  logic        err_q = 1'b0;

  assign perr    = err_q;
  assign rd_data = (address < 32'd16) ? mem[address[3:0]] : 32'h0;

  always @(posedge clk) begin
    err_q <= (rd_en || wr_en) && pready && (address >= 32'd16);
    if (wr_en && pready && (address < 32'd16)) begin
      mem[address[3:0]] <= wr_data;
      wlog_a.push_back(address);
      wlog_d.push_back(wr_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic xfer(
    input  logic [31:0] a,
    input  logic        w,
    input  logic [2:0]  sz,
    input  logic [31:0] d,
    input  int          stall,
    output int          waits,
    output int          rsp,
    output int          nrd,
    output int          nwr,
    output int          bad
  );
    logic [31:0] wa;
    wa = {2'b00, a[31:2]};
    @(negedge clk);
    HSEL   = 1'b1;
    HADDR  = a;
    HWRITE = w;
    HTRANS = HTRANS_NONSEQ;
    HSIZE  = sz;
    pready = (stall == 0);
    @(negedge clk);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWDATA = d;
    waits = 0; rsp = 0; nrd = 0; nwr = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (HRESP) rsp++;
      if (rd_en) nrd++;
      if (wr_en) nwr++;
      if (rd_en || wr_en) begin
        if (address !== wa) bad++;
        if (nrd + nwr > stall) pready = 1'b1;
      end
      if (HREADYOUT) break;
      waits++;
      @(negedge clk);
    end
    if (waits >= 60) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout got %0d cycles expected <60", waits);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    int          rsp;
    int          nrd;
    int          nwr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [12];

  initial begin
    int w, r, nr, nw, b, n;

    vt[0]  = '{32'h08,  1'b1, 3'b010, 32'hDEADBEEF, 2, 0, 0, 1, 32'h0};
    vt[1]  = '{32'h08,  1'b0, 3'b010, 32'h0,        2, 0, 1, 0, 32'hDEADBEEF};
    vt[2]  = '{32'h3C,  1'b1, 3'b010, 32'h12345678, 2, 0, 0, 1, 32'hDEADBEEF};
    vt[3]  = '{32'h3C,  1'b0, 3'b010, 32'h0,        2, 0, 1, 0, 32'h12345678};
    vt[4]  = '{32'h100, 1'b0, 3'b010, 32'h0,        3, 2, 1, 0, 32'h0};
    vt[5]  = '{32'h10,  1'b1, 3'b001, 32'h55555555, 1, 2, 0, 0, 32'h0};
    vt[6]  = '{32'h06,  1'b0, 3'b010, 32'h0,        1, 2, 0, 0, 32'h0};
    vt[7]  = '{32'h04,  1'b1, 3'b010, 32'hCAFEF00D, 2, 0, 0, 1, 32'h0};
    vt[8]  = '{32'h04,  1'b0, 3'b010, 32'h0,        2, 0, 1, 0, 32'hCAFEF00D};
    vt[9]  = '{32'h200, 1'b1, 3'b010, 32'h77777777, 3, 2, 0, 1, 32'hCAFEF00D};
    vt[10] = '{32'h00,  1'b0, 3'b010, 32'h0,        2, 0, 1, 0, 32'h0};
    vt[11] = '{32'h08,  1'b0, 3'b010, 32'h0,        2, 0, 1, 0, 32'hDEADBEEF};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0;
    HTRANS = HTRANS_IDLE; HSIZE = HSIZE_WORD; HWDATA = '0;
    pready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_address", address, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_strobe", {30'b0, rd_en, wr_en}, 32'd0);

    // IDLE, BUSY and deselected NONSEQ: zero-wait OKAY.
    HSEL = 1'b1; HTRANS = HTRANS_IDLE;
    @(negedge clk);
    chk("idle_ready", {31'b0, HREADYOUT}, 32'd1);
    chk("idle_strobe", {30'b0, rd_en, wr_en}, 32'd0);
    HTRANS = HTRANS_BUSY;
    @(negedge clk);
    chk("busy_ready", {31'b0, HREADYOUT}, 32'd1);
    chk("busy_resp", {31'b0, HRESP}, 32'd0);
    HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = 32'h08;
    @(negedge clk);
    chk("nosel_ready", {31'b0, HREADYOUT}, 32'd1);
    chk("nosel_strobe", {30'b0, rd_en, wr_en}, 32'd0);
    HTRANS = HTRANS_IDLE;

    for (int i = 0; i < 12; i++) begin
      xfer(vt[i].addr, vt[i].wr, vt[i].size, vt[i].wdata, 0,
           w, r, nr, nw, b);
      chk($sformatf("v%0d_waits", i), w, vt[i].waits);
      chk($sformatf("v%0d_rsp", i), r, vt[i].rsp);
      chk($sformatf("v%0d_nrd", i), nr, vt[i].nrd);
      chk($sformatf("v%0d_nwr", i), nw, vt[i].nwr);
      chk($sformatf("v%0d_addr", i), b, 0);
      chk($sformatf("v%0d_hrdata", i), HRDATA, vt[i].rdata);
    end

    // Peripheral stalls three cycles during a write.
    xfer(32'h0C, 1'b1, HSIZE_WORD, 32'h11112222, 3, w, r, nr, nw, b);
    chk("stall_waits", w, 5);
    chk("stall_nwr", nw, 4);
    chk("stall_nrd", nr, 0);
    chk("stall_addr", b, 0);
    chk("stall_rsp", r, 0);
    xfer(32'h0C, 1'b0, HSIZE_WORD, 32'h0, 0, w, r, nr, nw, b);
    chk("stall_readback", HRDATA, 32'h11112222);

    // Back-to-back writes, second address phase pending.
    wlog_a.delete();
    wlog_d.delete();
    @(negedge clk);
    HSEL = 1'b1; HADDR = 32'h00; HWRITE = 1'b1;
    HTRANS = HTRANS_NONSEQ; HSIZE = HSIZE_WORD; pready = 1'b1;
    @(negedge clk);
    HWDATA = 32'hA0A0A0A0; HADDR = 32'h04;
    n = 0;
    while (!HREADYOUT && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_waits", n, 2);
    @(negedge clk);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hB1B1B1B1;
    chk("b2b_second_wr_en", {31'b0, wr_en}, 32'd1);
    chk("b2b_second_addr", address, 32'd1);
    n = 0;
    while (!HREADYOUT && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_waits", n, 2);
    chk("b2b_wlog_len", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk("b2b_w0_addr", wlog_a[0], 32'd0);
      chk("b2b_w0_data", wlog_d[0], 32'hA0A0A0A0);
      chk("b2b_w1_addr", wlog_a[1], 32'd1);
      chk("b2b_w1_data", wlog_d[1], 32'hB1B1B1B1);
    end

    // Reset asserted in the middle of an ACCESS.
    @(negedge clk);
    HSEL = 1'b1; HADDR = 32'h08; HWRITE = 1'b0;
    HTRANS = HTRANS_NONSEQ; HSIZE = HSIZE_WORD; pready = 1'b0;
    @(negedge clk);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    chk("mid_in_access", {31'b0, rd_en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("mid_hresp", {31'b0, HRESP}, 32'd0);
    chk("mid_rd_en", {31'b0, rd_en}, 32'd0);
    chk("mid_wr_en", {31'b0, wr_en}, 32'd0);
    chk("mid_address", address, 32'h0);
    chk("mid_hrdata", HRDATA, 32'h0);
    @(negedge clk);
    pready = 1'b1;
    rst = 1'b1;
    HSEL = 1'b1; HTRANS = HTRANS_IDLE;
    @(negedge clk);
    chk("rel_strobe", {30'b0, rd_en, wr_en}, 32'd0);
    chk("rel_idle_ready", {31'b0, HREADYOUT}, 32'd1);
    chk("rel_idle_resp", {31'b0, HRESP}, 32'd0);
    HSEL = 1'b0;
    xfer(32'h08, 1'b0, HSIZE_WORD, 32'h0, 0, w, r, nr, nw, b);
    chk("rel_read_waits", w, 2);
    chk("rel_read_data", HRDATA, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
